// File: rtl/match_phase_seq.sv
// match_phase_seq
//   Streaming phase matcher. Stores one reference row of unwrapped phase, then
//   for each pixel of every following target row finds the nearest reference
//   index with a forward-only (two-pointer) search.
//
// Ports
//   aclk, areset         clock, synchronous active-high reset
//   match_th             max accepted |ref-tgt|, latched at target-row start
//   ref_hold             1 = reuse the stored reference for the next target row
//   len_err              sticky row-length error, cleared only by reset
//   s_axis_*             phase input stream, lane 0 = lowest column
//   m_axis_*             matched reference index per lane, or NO_MATCH
module match_phase_seq #(
  parameter int ROW_SIZE   = 1280,
  parameter int BEAT_SIZE  = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [DATA_WIDTH-1:0]            match_th,
  input  logic                             ref_hold,
  output logic                             len_err,
  input  logic [BEAT_SIZE*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [BEAT_SIZE*DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast
);

  localparam int DEPTH = ROW_SIZE / BEAT_SIZE;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int LW    = (BEAT_SIZE > 1) ? $clog2(BEAT_SIZE) : 1;
  localparam int BW    = BEAT_SIZE * DATA_WIDTH;
  localparam int DW1   = DATA_WIDTH + 1;

  localparam logic [DATA_WIDTH-1:0] NO_MATCH  = '1;
  localparam logic [DATA_WIDTH-1:0] P_LAST    = DATA_WIDTH'(ROW_SIZE - 1);
  localparam logic [LW-1:0]         LANE_LAST = LW'(BEAT_SIZE - 1);
  localparam logic [CW-1:0]         CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_LAST  = CW'(DEPTH - 1);

  typedef enum logic [2:0] {
    LOAD_REF,
    ROW_START,
    FETCH,
    TGT_WAIT,
    CMP
  } state_t;

  state_t                  state;
  logic                    run;       // low during reset so tready stays low
  logic [CW-1:0]           w_cnt;     // reference beats seen, saturates at DEPTH
  logic [CW-1:0]           t_cnt;     // target beats seen, saturates at DEPTH
  logic [DATA_WIDTH-1:0]   p_idx;     // search pointer as a column index
  logic [LW-1:0]           p_lane;    // pointer lane inside the fetched ref beat
  logic [AW-1:0]           p_beat;    // pointer beat address
  logic [DATA_WIDTH-1:0]   prev;      // ref[p-1]
  logic [DATA_WIDTH-1:0]   th_q;
  logic [BW-1:0]           tgt;
  logic [LW-1:0]           tgt_lane;
  logic                    tgt_last;
  logic                    tgt_held;  // a target beat is mid-resolution

  logic [BW-1:0]           ram [DEPTH];
  logic [BW-1:0]           ref_q;
  logic                    ram_we;
  logic                    rd_en;
  logic [AW-1:0]           rd_addr;
  logic                    s_fire;

  function automatic logic [DW1-1:0] abs_diff(input logic [DATA_WIDTH-1:0] a,
                                              input logic [DATA_WIDTH-1:0] b);
    return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

  // Input is accepted while loading, or while waiting for a target beat with
  // the output register free. Only registered state feeds this decode.
  assign s_axis_tready = run && ((state == LOAD_REF) ||
                                 (state == TGT_WAIT && !m_axis_tvalid));
  assign s_fire = s_axis_tvalid && s_axis_tready;
  assign ram_we = (state == LOAD_REF) && s_fire && (w_cnt != CNT_FULL);

  // Comparison datapath for the current lane and pointer.
  logic [DATA_WIDTH-1:0] t_px, cur_px, res_idx, result;
  logic [DW1-1:0]        d0, d1, best;
  logic                  advance, pick_prev;

  assign t_px      = tgt[tgt_lane*DATA_WIDTH +: DATA_WIDTH];
  assign cur_px    = ref_q[p_lane*DATA_WIDTH +: DATA_WIDTH];
  assign advance   = (cur_px < t_px) && (p_idx != P_LAST);
  assign d1        = abs_diff(cur_px, t_px);
  assign d0        = (p_idx != '0) ? abs_diff(prev, t_px) : '1;
  assign pick_prev = d0 < d1;                 // ties resolve to the higher index
  assign best      = pick_prev ? d0 : d1;
  assign res_idx   = pick_prev ? p_idx - 1'b1 : p_idx;
  assign result    = (best > {1'b0, th_q}) ? NO_MATCH : res_idx;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if (state == ROW_START) begin
      rd_en = 1'b1;
    end else if (state == CMP && advance && p_lane == LANE_LAST) begin
      rd_en   = 1'b1;
      rd_addr = p_beat + 1'b1;
    end
  end

  // NOTE: the reference RAM has no reset; its contents are only ever read
  // after a complete reference load has rewritten them.
  always_ff @(posedge aclk) begin
    if (ram_we) ram[w_cnt[AW-1:0]] <= s_axis_tdata;
    if (rd_en)  ref_q <= ram[rd_addr];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= LOAD_REF;
      run           <= 1'b0;
      len_err       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      w_cnt         <= '0;
      t_cnt         <= '0;
      p_idx         <= '0;
      p_lane        <= '0;
      p_beat        <= '0;
      prev          <= '0;
      th_q          <= '0;
      tgt           <= '0;
      tgt_lane      <= '0;
      tgt_last      <= 1'b0;
      tgt_held      <= 1'b0;
    end else begin
      run <= 1'b1;
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

      case (state)
        LOAD_REF: begin
          if (s_fire) begin
            // Beats past the RAM depth are dropped and flagged.
            if (w_cnt != CNT_FULL) w_cnt <= w_cnt + 1'b1;
            else                   len_err <= 1'b1;
            if (s_axis_tlast) begin
              if (w_cnt != CNT_LAST) len_err <= 1'b1;
              w_cnt <= '0;
              state <= ROW_START;
            end
          end
        end

        ROW_START: begin
          p_idx  <= '0;
          p_lane <= '0;
          p_beat <= '0;
          prev   <= '0;
          t_cnt  <= '0;
          th_q   <= match_th;
          state  <= FETCH;
        end

        FETCH: state <= tgt_held ? CMP : TGT_WAIT;

        TGT_WAIT: begin
          if (s_fire) begin
            tgt      <= s_axis_tdata;
            tgt_lane <= '0;
            tgt_last <= s_axis_tlast;
            tgt_held <= 1'b1;
            if (t_cnt != CNT_FULL) t_cnt <= t_cnt + 1'b1;
            else                   len_err <= 1'b1;
            if (s_axis_tlast && t_cnt != CNT_LAST) len_err <= 1'b1;
            state <= CMP;
          end
        end

        CMP: begin
          if (advance) begin
            prev  <= cur_px;
            p_idx <= p_idx + 1'b1;
            if (p_lane == LANE_LAST) begin
              p_lane <= '0;
              p_beat <= p_beat + 1'b1;
              state  <= FETCH;
            end else begin
              p_lane <= p_lane + 1'b1;
            end
          end else begin
            // Output register is empty throughout CMP, so lanes fill in place.
            m_axis_tdata[tgt_lane*DATA_WIDTH +: DATA_WIDTH] <= result;
            if (tgt_lane == LANE_LAST) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= tgt_last;
              tgt_held      <= 1'b0;
              if (!tgt_last)     state <= TGT_WAIT;
              else if (ref_hold) state <= ROW_START;
              else               state <= LOAD_REF;
            end else begin
              tgt_lane <= tgt_lane + 1'b1;
            end
          end
        end

        default: state <= LOAD_REF;
      endcase
    end
  end

endmodule
